// File: rtl/sockit_spi_ser.sv
// ---------------------------------------------------------------------------
// sockit_spi_ser
// Serializer and SPI pin engine on the SPI-clock side of the master.
// Pops command words from the CDC FIFO (ctl_* vld/rdy), shifts them out
// MSB-first on 1, 2 or 4 lanes in SPI mode 0 (SCLK = spi_clk/2, idles low).
// It captures the input lanes on each SCLK rise and, when asked, pushes the
// captured word into the return FIFO (rdt_* vld/rdy).
//
// Ports
//   spi_clk, spi_rst   clock, asynchronous active-low reset
//   spi_clr            synchronous abort, returns to idle with ss_n high
//   ctl_dat/len/iom    TX word, SCLK cycle count, lane mode (00/11 single,
//                      01 dual, 10 quad)
//   ctl_oen            drive the active lanes (single mode always drives sio[0])
//   ctl_ssn            release ss_n after this command
//   ctl_rdr            return captured data on rdt_*
//   ctl_vld/ctl_rdy    command handshake (ctl_rdy high only while idle)
//   rdt_dat/vld/rdy    captured read data handshake
//   spi_sclk, spi_ssn  SPI clock and slave select
//   sio_o/sio_e/sio_i  lane outputs, output enables, lane inputs
// ---------------------------------------------------------------------------
module sockit_spi_ser #(
  parameter int unsigned DW = 32,
  parameter int unsigned LW = 6
) (
  input  logic          spi_clk,
  input  logic          spi_rst,
  input  logic          spi_clr,
  input  logic [DW-1:0] ctl_dat,
  input  logic [LW-1:0] ctl_len,
  input  logic [1:0]    ctl_iom,
  input  logic          ctl_oen,
  input  logic          ctl_ssn,
  input  logic          ctl_rdr,
  input  logic          ctl_vld,
  output logic          ctl_rdy,
  output logic [DW-1:0] rdt_dat,
  output logic          rdt_vld,
  input  logic          rdt_rdy,
  output logic          spi_sclk,
  output logic          spi_ssn,
  output logic [3:0]    sio_o,
  output logic [3:0]    sio_e,
  input  logic [3:0]    sio_i
);

  localparam logic [1:0] IOM_DUAL = 2'b01;
  localparam logic [1:0] IOM_QUAD = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    DONE = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t        state;
  logic [DW-1:0] tx;
  logic [DW-1:0] rx;
  logic [LW-1:0] cnt;
  logic [1:0]    iom;
  logic          ssn_q;
  logic          rdr_q;

  // Lane values presented for the current top-of-shifter bits.
  function automatic logic [3:0] lane_out(input logic [DW-1:0] d, input logic [1:0] m);
    case (m)
      IOM_DUAL: lane_out = {2'b00, d[DW-1 -: 2]};
      IOM_QUAD: lane_out = d[DW-1 -: 4];
      default:  lane_out = {3'b000, d[DW-1]};
    endcase
  endfunction

  // Output enables: single mode always owns MOSI, multi-lane follows ctl_oen.
  function automatic logic [3:0] lane_en(input logic [1:0] m, input logic oen);
    case (m)
      IOM_DUAL: lane_en = oen ? 4'b0011 : 4'b0000;
      IOM_QUAD: lane_en = oen ? 4'b1111 : 4'b0000;
      default:  lane_en = 4'b0001;
    endcase
  endfunction

  // TX shift by the lane count, zero fill so over-long commands send zeros.
  function automatic logic [DW-1:0] shift_tx(input logic [DW-1:0] d, input logic [1:0] m);
    case (m)
      IOM_DUAL: shift_tx = {d[DW-3:0], 2'b00};
      IOM_QUAD: shift_tx = {d[DW-5:0], 4'b0000};
      default:  shift_tx = {d[DW-2:0], 1'b0};
    endcase
  endfunction

  // RX shift; single mode reads MISO on sio[1], older bits fall off the top.
  function automatic logic [DW-1:0] shift_rx(input logic [DW-1:0] r, input logic [1:0] m,
                                             input logic [3:0] i);
    case (m)
      IOM_DUAL: shift_rx = {r[DW-3:0], i[1:0]};
      IOM_QUAD: shift_rx = {r[DW-5:0], i};
      default:  shift_rx = {r[DW-2:0], i[1]};
    endcase
  endfunction

  // Pin engine FSM; every output is a register.
  always_ff @(posedge spi_clk or negedge spi_rst) begin
    if (!spi_rst) begin
      state    <= IDLE;
      tx       <= '0;
      rx       <= '0;
      cnt      <= '0;
      iom      <= 2'b00;
      ssn_q    <= 1'b0;
      rdr_q    <= 1'b0;
      ctl_rdy  <= 1'b1;
      rdt_dat  <= '0;
      rdt_vld  <= 1'b0;
      spi_sclk <= 1'b0;
      spi_ssn  <= 1'b1;
      sio_o    <= 4'b0000;
      sio_e    <= 4'b0000;
    end else if (spi_clr) begin
      // Abort wins over everything, including a command handshake this cycle.
      state    <= IDLE;
      ctl_rdy  <= 1'b1;
      rdt_vld  <= 1'b0;
      spi_sclk <= 1'b0;
      spi_ssn  <= 1'b1;
      sio_o    <= 4'b0000;
      sio_e    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (ctl_vld && ctl_rdy) begin
            tx      <= ctl_dat;
            rx      <= '0;
            cnt     <= ctl_len;
            iom     <= ctl_iom;
            ssn_q   <= ctl_ssn;
            rdr_q   <= ctl_rdr;
            sio_o   <= lane_out(ctl_dat, ctl_iom);
            sio_e   <= lane_en(ctl_iom, ctl_oen);
            spi_ssn <= 1'b0;
            ctl_rdy <= 1'b0;
            state   <= (ctl_len == '0) ? DONE : LOW;
          end
        end
        LOW: begin
          // Mode 0: slave data is sampled on the SCLK rising edge.
          rx       <= shift_rx(rx, iom, sio_i);
          spi_sclk <= 1'b1;
          state    <= HIGH;
        end
        HIGH: begin
          // Falling edge: advance the shifter so new data is set up for the next rise.
          tx       <= shift_tx(tx, iom);
          sio_o    <= lane_out(shift_tx(tx, iom), iom);
          cnt      <= cnt - LW'(1);
          spi_sclk <= 1'b0;
          state    <= (cnt != LW'(1)) ? LOW : DONE;
        end
        DONE: begin
          sio_e <= 4'b0000;
          if (ssn_q) spi_ssn <= 1'b1;
          if (rdr_q) begin
            rdt_dat <= rx;
            rdt_vld <= 1'b1;
            state   <= RESP;
          end else begin
            ctl_rdy <= 1'b1;
            state   <= IDLE;
          end
        end
        RESP: begin
          if (rdt_rdy) begin
            rdt_vld <= 1'b0;
            ctl_rdy <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          ctl_rdy <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
